hilo_mdu: RTL and testbench
===========================

# hilo_mdu

Parametrised iterative multiply/divide/accumulate unit for the HI/LO datapath. It replaces the single-cycle multiply and two-pass MADD/MSUB stall scheme with a start/ready multicycle engine. It executes MULT/MULTU, MADD/MADDU, MSUB/MSUBU, DIV and DIVU, and returns a 2×WIDTH {HI, LO} result. It sits beside the EX stage, which holds `start_i` for one cycle, stalls on `busy_o`, and takes `result_o` when `ready_o` is asserted.

## Interface
- `WIDTH`, default 32: operand width; the result is 2×WIDTH.
- `MUL_BPC`, default 1: multiplier bits consumed per cycle. It must be a power of two that divides WIDTH.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start_i`  in  1  launch request. It is accepted only in IDLE or DONE, and only when `annul_i` is low.
- `annul_i`  in  1  abort the current operation (pipeline flush).
- `op_i`  in  3  operation code: 000 MULTU, 001 MULT, 010 MADDU, 011 MADD, 100 MSUBU, 101 MSUB, 110 DIVU, 111 DIV.
- `opdata1_i`  in  WIDTH  multiplicand / dividend.
- `opdata2_i`  in  WIDTH  multiplier / divisor.
- `hilo_i`  in  2×WIDTH  current {HI, LO}, already forwarded by EX; it is the accumulate operand.
- `result_o`  out  2×WIDTH  {HI, LO} result; it holds until the next accepted start.
- `ready_o`  out  1  one-cycle pulse; `result_o` is valid while it is high.
- `busy_o`  out  1  high in CALC and FIX.
- `div_by_zero_o`  out  1  qualifies the last result; it is updated together with `result_o`.

## Operation
- States and transitions:
  - IDLE → CALC on an accepted start.
  - CALC → FIX after N iterations. N = WIDTH/MUL_BPC for multiply ops, N = WIDTH for divide ops.
  - CALC → DONE after one cycle if the op is a divide and the divisor is 0.
  - FIX → DONE.
  - DONE → CALC on an accepted start, else DONE → IDLE.
- On accept, capture the op, the operand magnitudes, the operand sign bits and `hilo_i`. Later changes on the inputs are ignored.
- Signed ops (the odd codes) take the two's-complement magnitude of each negative operand. Unsigned ops use the raw operands.
- Multiply iteration: shift-add, consuming MUL_BPC multiplier bits per cycle into a 2×WIDTH partial product.
- Divide iteration: restoring, one quotient bit per cycle.
- FIX, multiply ops: negate the product if the operand signs differ (signed ops only).
  - MADD/MADDU: result = captured hilo + product.
  - MSUB/MSUBU: result = captured hilo − product.
  - All arithmetic is modulo 2^(2×WIDTH); no overflow flag is produced.
- FIX, divide ops:
  - Quotient is negated if the signs differ (DIV only).
  - Remainder takes the dividend's sign.
  - `result_o` = {remainder, quotient}, i.e. HI = remainder and LO = quotient.
  - DIV of −2^(WIDTH−1) by −1 wraps: quotient = 0x8000_0000 (WIDTH=32), remainder = 0.
- Divide by zero: `result_o` = 0 and `div_by_zero_o` = 1. For every other op `div_by_zero_o` = 0.
- `annul_i` high in CALC, FIX or DONE:
  - The next state is IDLE.
  - No `ready_o` is produced.
  - `result_o` and `div_by_zero_o` keep their previous values.
  - A simultaneous `start_i` is ignored.
- `start_i` in CALC or FIX is ignored; it is neither queued nor an error.

## Timing
- Reset values: `result_o` = 0, `ready_o` = 0, `busy_o` = 0, `div_by_zero_o` = 0, state = IDLE. Asynchronous reset mid-operation drops any operation in progress immediately.
- All outputs are registered.
- Latency: the edge that samples the start is edge 0. `ready_o` rises after edge N+1 and falls after edge N+2 unless a new operation completes.
  - WIDTH=32, MUL_BPC=1: MULT rises after edge 33.
  - WIDTH=32, MUL_BPC=4: MULT rises after edge 9.
  - Divide by zero: rises after edge 1.
- `busy_o` is high from edge 0 through edge N+1, exclusive, i.e. while in CALC and FIX.
- Back-to-back: a start accepted during the DONE cycle puts the next operation into CALC on the following edge, with no idle bubble.

## Test plan
- MULT, −3 × 5 (0xFFFFFFFD, 0x00000005), WIDTH=32, MUL_BPC=1 → `result_o` = 0xFFFFFFFF_FFFFFFF1. `ready_o` pulses exactly once, after edge 33. `busy_o` is high for 33 cycles.
- MADD, `hilo_i` = 0x0000_0000_0000_0010, 7 × 6 → 0x0000_0000_0000_003A. MSUBU, `hilo_i` = 0x0000_0001_0000_0000, 2 × 3 → 0x0000_0000_FFFF_FFFA.
- DIV, −7 / 2 → {0xFFFFFFFF, 0xFFFFFFFD}. DIVU, 100 / 7 → {0x00000002, 0x0000000E}. DIV, 0x80000000 / 0xFFFFFFFF → {0x00000000, 0x80000000}.
- DIVU, 5 / 0 → `ready_o` after edge 1, `result_o` = 0, `div_by_zero_o` = 1. A following MULTU, 2 × 2, gives 4 with `div_by_zero_o` = 0.
- Abort and reset cases:
  - `annul_i` asserted in CALC cycle 10 → IDLE next edge, no `ready_o`, `result_o` unchanged. A new start then completes normally.
  - Async `rst` pulse mid-CALC → all outputs 0 immediately.
- MUL_BPC=4:
  - MULTU, 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE_00000001, ready after edge 9.
  - A start issued during DONE launches the next op with no bubble.
  - A start issued during CALC is ignored.

Source files
------------

// File: rtl/hilo_mdu.sv
// Iterative HI/LO multiply/divide/accumulate engine with a start/ready handshake.
// Multiplies use shift-add (MUL_BPC bits per cycle); divides use restoring division (one bit per cycle).
module hilo_mdu #(
    parameter int WIDTH   = 32,
    parameter int MUL_BPC = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic                 annul_i,
    input  logic [2:0]           op_i,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    input  logic [2*WIDTH-1:0]   hilo_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 ready_o,
    output logic                 busy_o,
    output logic                 div_by_zero_o
);

    localparam int DW    = 2 * WIDTH;
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(WIDTH / MUL_BPC - 1);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t             state, next_state;
    logic [2:0]         op_q;
    logic               sign_a, sign_b;
    logic [DW-1:0]      hilo_q;
    logic [DW-1:0]      acc;      // product, or {remainder, dividend/quotient}
    logic [DW-1:0]      mcand;
    logic [WIDTH-1:0]   mplier;   // multiplier, or divisor
    logic [CNT_W-1:0]   cnt;

    logic               neg_a_in, neg_b_in, accept, is_div, div_zero;
    logic [WIDTH-1:0]   mag_a_in, mag_b_in;
    logic [DW-1:0]      partial, div_next, prod_s, fix_result;
    logic [WIDTH:0]     rem_shift, rem_diff;
    logic               rem_ge;
    logic [WIDTH-1:0]   quot_s, rem_s;

    // Signed ops (odd codes) work on magnitudes and fix the signs in FIX.
    assign neg_a_in = op_i[0] & opdata1_i[WIDTH-1];
    assign neg_b_in = op_i[0] & opdata2_i[WIDTH-1];
    assign mag_a_in = neg_a_in ? -opdata1_i : opdata1_i;
    assign mag_b_in = neg_b_in ? -opdata2_i : opdata2_i;

    assign accept   = start_i & ~annul_i & ((state == IDLE) | (state == DONE));
    assign is_div   = op_q[2] & op_q[1];
    assign div_zero = is_div & (mplier == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (accept) next_state = CALC;
            CALC: begin
                if (annul_i)          next_state = IDLE;
                else if (div_zero)    next_state = DONE;
                else if (cnt == '0)   next_state = FIX;
            end
            FIX:  next_state = annul_i ? IDLE : DONE;
            DONE: next_state = accept ? CALC : IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        partial = '0;
        for (int j = 0; j < MUL_BPC; j++)
            if (mplier[j]) partial = partial + (mcand << j);
    end

    assign rem_shift = acc[DW-1:WIDTH-1];
    assign rem_ge    = rem_shift >= {1'b0, mplier};
    assign rem_diff  = rem_shift - {1'b0, mplier};
    assign div_next  = rem_ge ? {rem_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1}
                              : {acc[DW-2:0], 1'b0};

    assign prod_s = (op_q[0] & (sign_a ^ sign_b)) ? -acc : acc;
    assign quot_s = (op_q[0] & (sign_a ^ sign_b)) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign rem_s  = (op_q[0] & sign_a) ? -acc[DW-1:WIDTH] : acc[DW-1:WIDTH];

    always_comb begin
        fix_result = prod_s;
        case (op_q[2:1])
            2'b01:   fix_result = hilo_q + prod_s;
            2'b10:   fix_result = hilo_q - prod_s;
            2'b11:   fix_result = {rem_s, quot_s};
            default: fix_result = prod_s;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q   <= '0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            hilo_q <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else if (accept) begin
            op_q   <= op_i;
            sign_a <= neg_a_in;
            sign_b <= neg_b_in;
            hilo_q <= hilo_i;
            mcand  <= {{WIDTH{1'b0}}, mag_a_in};
            mplier <= mag_b_in;
            acc    <= (op_i[2] & op_i[1]) ? {{WIDTH{1'b0}}, mag_a_in} : '0;
            cnt    <= (op_i[2] & op_i[1]) ? DIV_LAST : MUL_LAST;
        end else if (state == CALC) begin
            cnt <= cnt - CNT_W'(1);
            if (is_div) begin
                acc <= div_next;
            end else begin
                acc    <= acc + partial;
                mcand  <= mcand << MUL_BPC;
                mplier <= mplier >> MUL_BPC;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_o      <= '0;
            ready_o       <= 1'b0;
            busy_o        <= 1'b0;
            div_by_zero_o <= 1'b0;
        end else begin
            ready_o <= (next_state == DONE);
            busy_o  <= (next_state == CALC) | (next_state == FIX);
            if (state == CALC && next_state == DONE) begin
                result_o      <= '0;
                div_by_zero_o <= 1'b1;
            end else if (state == FIX && next_state == DONE) begin
                result_o      <= fix_result;
                div_by_zero_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_hilo_mdu.sv
// Directed bench for hilo_mdu: one instance with MUL_BPC=1 and one with MUL_BPC=4.
module tb_hilo_mdu;

    logic        clk = 1'b0;
    logic        rst, start_1, start_4, annul;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic [63:0] hilo;
    logic [63:0] res1, res4;
    logic        rdy1, busy1, dbz1, rdy4, busy4, dbz4;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    hilo_mdu #(.WIDTH(32), .MUL_BPC(1)) dut (
        .clk(clk), .rst(rst), .start_i(start_1), .annul_i(annul), .op_i(op),
        .opdata1_i(a), .opdata2_i(b), .hilo_i(hilo), .result_o(res1),
        .ready_o(rdy1), .busy_o(busy1), .div_by_zero_o(dbz1)
    );

    hilo_mdu #(.WIDTH(32), .MUL_BPC(4)) dut4 (
        .clk(clk), .rst(rst), .start_i(start_4), .annul_i(annul), .op_i(op),
        .opdata1_i(a), .opdata2_i(b), .hilo_i(hilo), .result_o(res4),
        .ready_o(rdy4), .busy_o(busy4), .div_by_zero_o(dbz4)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Launch one op (called #1 after a rising edge) and watch it for 45 cycles.
    task automatic run_op(input bit use4, input logic [2:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [63:0] h,
                          output logic [63:0] r, output int lat, output int busy_n,
                          output int pulses, output logic z);
        op = o; a = x; b = y; hilo = h;
        if (use4) start_4 = 1'b1; else start_1 = 1'b1;
        @(posedge clk); #1;
        start_1 = 1'b0; start_4 = 1'b0;
        lat = -1; busy_n = 0; pulses = 0; r = 'x; z = 1'bx;
        for (int k = 0; k < 45; k++) begin
            if (use4 ? busy4 : busy1) busy_n++;
            if (use4 ? rdy4 : rdy1) begin
                pulses++;
                if (lat < 0) begin
                    lat = k;
                    r   = use4 ? res4 : res1;
                    z   = use4 ? dbz4 : dbz1;
                end
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [63:0] r;
        logic        z;
        int          lat, busy_n, pulses;

        rst = 1'b1; start_1 = 1'b0; start_4 = 1'b0; annul = 1'b0;
        op = 3'b000; a = '0; b = '0; hilo = '0;
        #12;
        check("reset_result", res1, 64'h0);
        check("reset_ready", {63'h0, rdy1}, 64'h0);
        check("reset_busy", {63'h0, busy1}, 64'h0);
        check("reset_dbz", {63'h0, dbz1}, 64'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        // MULT -3 x 5, with a non-zero hilo that must not leak into the result
        run_op(0, 3'b001, 32'hFFFF_FFFD, 32'h5, 64'hDEAD_BEEF_0123_4567, r, lat, busy_n, pulses, z);
        check("mult_result", r, 64'hFFFF_FFFF_FFFF_FFF1);
        check("mult_latency", 64'(lat), 64'd33);
        check("mult_busy_cycles", 64'(busy_n), 64'd33);
        check("mult_ready_pulses", 64'(pulses), 64'd1);

        run_op(0, 3'b011, 32'd7, 32'd6, 64'h0000_0000_0000_0010, r, lat, busy_n, pulses, z);
        check("madd_result", r, 64'h0000_0000_0000_003A);

        run_op(0, 3'b100, 32'd2, 32'd3, 64'h0000_0001_0000_0000, r, lat, busy_n, pulses, z);
        check("msubu_result", r, 64'h0000_0000_FFFF_FFFA);

        run_op(0, 3'b111, 32'hFFFF_FFF9, 32'd2, 64'h0, r, lat, busy_n, pulses, z);
        check("div_neg_result", r, {32'hFFFF_FFFF, 32'hFFFF_FFFD});

        run_op(0, 3'b110, 32'd100, 32'd7, 64'h0, r, lat, busy_n, pulses, z);
        check("divu_result", r, {32'h0000_0002, 32'h0000_000E});
        check("divu_latency", 64'(lat), 64'd33);

        run_op(0, 3'b111, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0, r, lat, busy_n, pulses, z);
        check("div_wrap_result", r, {32'h0000_0000, 32'h8000_0000});

        run_op(0, 3'b110, 32'd5, 32'd0, 64'h0, r, lat, busy_n, pulses, z);
        check("dbz_latency", 64'(lat), 64'd1);
        check("dbz_result", r, 64'h0);
        check("dbz_flag", {63'h0, z}, 64'h1);
        check("dbz_busy_cycles", 64'(busy_n), 64'd1);

        run_op(0, 3'b000, 32'd2, 32'd2, 64'h0, r, lat, busy_n, pulses, z);
        check("multu_after_dbz_result", r, 64'h4);
        check("multu_after_dbz_flag", {63'h0, z}, 64'h0);

        // Annul in CALC cycle 10, with a simultaneous start that must be dropped
        op = 3'b000; a = 32'd3; b = 32'd3;
        start_1 = 1'b1;
        @(posedge clk); #1;
        start_1 = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        annul = 1'b1; start_1 = 1'b1;
        @(posedge clk); #1;
        annul = 1'b0; start_1 = 1'b0;
        check("annul_busy", {63'h0, busy1}, 64'h0);
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            if (rdy1) pulses++;
            @(posedge clk); #1;
        end
        check("annul_no_ready", 64'(pulses), 64'd0);
        check("annul_result_kept", res1, 64'h4);
        check("annul_dbz_kept", {63'h0, dbz1}, 64'h0);

        run_op(0, 3'b001, 32'hFFFF_FFFE, 32'hFFFF_FFFC, 64'h0, r, lat, busy_n, pulses, z);
        check("after_annul_result", r, 64'h8);
        check("after_annul_latency", 64'(lat), 64'd33);

        // Asynchronous reset mid-CALC clears outputs before the next edge
        op = 3'b000; a = 32'd5; b = 32'd5;
        start_1 = 1'b1;
        @(posedge clk); #1;
        start_1 = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_result", res1, 64'h0);
        check("async_rst_busy", {63'h0, busy1}, 64'h0);
        check("async_rst_ready", {63'h0, rdy1}, 64'h0);
        check("async_rst_dbz", {63'h0, dbz1}, 64'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        // MUL_BPC = 4
        run_op(1, 3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0, r, lat, busy_n, pulses, z);
        check("bpc4_multu_result", r, 64'hFFFF_FFFE_0000_0001);
        check("bpc4_multu_latency", 64'(lat), 64'd9);
        check("bpc4_busy_cycles", 64'(busy_n), 64'd9);

        // Back-to-back start during DONE, then an ignored start during CALC
        op = 3'b000; a = 32'd3; b = 32'd4;
        start_4 = 1'b1;
        @(posedge clk); #1;
        start_4 = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("b2b_first_ready", {63'h0, rdy4}, 64'h1);
        check("b2b_first_result", res4, 64'd12);
        a = 32'd5; b = 32'd6;
        start_4 = 1'b1;
        @(posedge clk); #1;
        start_4 = 1'b0;
        check("b2b_no_bubble_busy", {63'h0, busy4}, 64'h1);
        check("b2b_ready_dropped", {63'h0, rdy4}, 64'h0);
        repeat (2) @(posedge clk);
        #1;
        a = 32'd7; b = 32'd7;
        start_4 = 1'b1;
        @(posedge clk); #1;
        start_4 = 1'b0;
        check("calc_start_busy", {63'h0, busy4}, 64'h1);
        repeat (6) @(posedge clk);
        #1;
        check("b2b_second_ready", {63'h0, rdy4}, 64'h1);
        check("b2b_second_result", res4, 64'd30);
        @(posedge clk); #1;
        check("b2b_ready_pulse_end", {63'h0, rdy4}, 64'h0);
        check("b2b_idle_busy", {63'h0, busy4}, 64'h0);
        pulses = 0;
        for (int k = 0; k < 20; k++) begin
            if (rdy4) pulses++;
            @(posedge clk); #1;
        end
        check("calc_start_ignored", 64'(pulses), 64'd0);
        check("calc_start_result_kept", res4, 64'd30);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
